bp_sacc_spm_arbiter: RTL and testbench
======================================

Name: bp_sacc_spm_arbiter

Overview:
- Shares the accelerator's single-port 1RW synchronous scratchpad (64-bit words, 1-cycle read latency) between two requesters: the external uncached I/O path (CSR/SPM window) and the internal compute sequencer.
- Arbitrates per cycle, drives the SRAM port, and routes read data back to the requester that issued the read.
- Holds the external response until it is consumed, and guarantees the external requester forward progress against a continuously requesting sequencer.

Parameters:
- data_width_p, 64, SPM word width.
- els_p, 20, SPM depth in words.
- addr_width_p, 40, requester byte-address width.
- starve_limit_p, 4, consecutive denied external cycles before external gets priority (range 1..15).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- ext_v_i  in  1  external request valid
- ext_w_i  in  1  external request is a write
- ext_addr_i  in  addr_width_p  external byte address
- ext_data_i  in  data_width_p  external write data
- ext_ready_o  out  1  external request accepted this cycle (valid/ready)
- ext_v_o  out  1  external response valid
- ext_data_o  out  data_width_p  external response data (0 for writes)
- ext_yumi_i  in  1  external response consumed
- int_v_i  in  1  internal request valid
- int_w_i  in  1  internal request is a write
- int_addr_i  in  addr_width_p  internal byte address
- int_data_i  in  data_width_p  internal write data
- int_ready_o  out  1  internal request accepted this cycle
- int_v_o  out  1  internal read data valid (no backpressure)
- int_data_o  out  data_width_p  internal read data
- mem_v_o  out  1  SRAM enable
- mem_w_o  out  1  SRAM write enable
- mem_addr_o  out  $clog2(els_p)  SRAM word index
- mem_data_o  out  data_width_p  SRAM write data
- mem_data_i  in  data_width_p  SRAM read data
- perf_conflicts_o  out  32  conflict counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe deassert): all regs cleared; ext_v_o, int_v_o, mem_v_o, mem_w_o, ext_ready_o and int_ready_o are 0; starve counter 0; pending reads dropped. Reset mid-read discards the read and the buffered response.
- Eligibility:
  - ext is eligible when ext_v_i=1 and the response buffer is empty and no ext read is in flight.
  - int is eligible when int_v_i=1.
- Grant:
  - Default priority is int.
  - ext wins when starve_cnt_r == starve_limit_p.
  - Exactly one grant per cycle. ready_o is combinational and equals grant.
- Starve counter:
  - Increments, saturating at starve_limit_p, on each cycle ext is eligible but not granted.
  - Clears on any ext grant, or on any cycle ext is not eligible.
- Address: word index = addr >> 3, low 3 bits ignored. If index >= els_p, the request is still accepted but mem_v_o is held 0, a read returns 0, and a write is dropped.
- SRAM drive: in the grant cycle, mem_v_o=1, mem_w_o=w, mem_addr_o=index, mem_data_o=granted data.
- Internal read: int_v_o=1 exactly one cycle after grant, with int_data_o=mem_data_i. Internal writes produce no response.
- External response buffer (1 entry):
  - A read loads mem_data_i one cycle after grant.
  - A write loads 0 one cycle after grant.
  - ext_v_o=1 while the buffer is full. The buffer clears on ext_yumi_i.
  - ext_yumi_i while ext_v_o=0 is ignored.
  - Because ext is ineligible while the buffer is full or a read is in flight, back-to-back ext requests have a minimum spacing of 2 cycles with same-cycle yumi.
- Simultaneous ext and int requests with the counter below the limit: int granted, ext waits.
- Consequences: read-after-write to the same index from either side returns the new data; at most one int read and one ext read are in flight.

Optional Feature:
- BP_SACC_SPM_ARB_PERF_EN defined: perf_conflicts_o is a 32-bit wrapping counter, incremented on each cycle both requesters are eligible, and cleared on reset.
- Not defined: the counter logic is absent and perf_conflicts_o is tied to 0.

Test Plan:
- ext write addr 0x10, data 0xDEAD, int idle -> ext_ready_o same cycle; mem_addr_o=2, mem_w_o=1; next cycle ext_v_o=1 with ext_data_o=0, held until yumi.
- ext read addr 0x10 after that write -> ext_v_o one cycle after grant with data 0xDEAD; ext_ready_o stays 0 until yumi.
- int_v_i held high for reads, ext read pending, starve_limit_p=4 -> ext denied 4 cycles and granted on the 5th; int_ready_o=0 that cycle; counter returns to 0.
- int read addr 0xA0 (index 20, els_p=20) -> accepted, mem_v_o=0, int_v_o next cycle with data 0.
- reset_i asserted the cycle after an ext read grant -> ext_v_o stays 0 after release, and the buffer is empty.
- With BP_SACC_SPM_ARB_PERF_EN, 3 cycles of dual eligibility -> perf_conflicts_o=3. Without the macro -> perf_conflicts_o=0.

Source files
------------

// File: rtl/bp_sacc_spm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bp_sacc_spm_arbiter_if
//  Purpose  : Bundles the two requester channels and the SRAM port of the
//             scratchpad arbiter into one interface.
//             slave  - arbiter side (drives ready/response/SRAM outputs)
//             master - environment side (requesters and SRAM macro)
//  Signals  : ext_*  external uncached I/O requester (valid/ready request,
//                    valid/yumi response)
//             int_*  internal compute sequencer (valid/ready request,
//                    response without backpressure)
//             mem_*  1RW synchronous SRAM port, 1-cycle read latency
//             perf_conflicts_o  conflict counter (0 unless perf build)
//  Revision : 1.0  initial release
// ============================================================================
interface bp_sacc_spm_arbiter_if #(
  parameter int data_width_p = 64,
  parameter int els_p        = 20,
  parameter int addr_width_p = 40
);
  localparam int c_idx_w = (els_p > 1) ? $clog2(els_p) : 1;

  logic                    ext_v_i;
  logic                    ext_w_i;
  logic [addr_width_p-1:0] ext_addr_i;
  logic [data_width_p-1:0] ext_data_i;
  logic                    ext_ready_o;
  logic                    ext_v_o;
  logic [data_width_p-1:0] ext_data_o;
  logic                    ext_yumi_i;

  logic                    int_v_i;
  logic                    int_w_i;
  logic [addr_width_p-1:0] int_addr_i;
  logic [data_width_p-1:0] int_data_i;
  logic                    int_ready_o;
  logic                    int_v_o;
  logic [data_width_p-1:0] int_data_o;

  logic                    mem_v_o;
  logic                    mem_w_o;
  logic [c_idx_w-1:0]      mem_addr_o;
  logic [data_width_p-1:0] mem_data_o;
  logic [data_width_p-1:0] mem_data_i;

  logic [31:0]             perf_conflicts_o;

  modport slave (
    input  ext_v_i, ext_w_i, ext_addr_i, ext_data_i, ext_yumi_i,
    output ext_ready_o, ext_v_o, ext_data_o,
    input  int_v_i, int_w_i, int_addr_i, int_data_i,
    output int_ready_o, int_v_o, int_data_o,
    output mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
    input  mem_data_i,
    output perf_conflicts_o
  );

  modport master (
    output ext_v_i, ext_w_i, ext_addr_i, ext_data_i, ext_yumi_i,
    input  ext_ready_o, ext_v_o, ext_data_o,
    output int_v_i, int_w_i, int_addr_i, int_data_i,
    input  int_ready_o, int_v_o, int_data_o,
    input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
    output mem_data_i,
    input  perf_conflicts_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_sacc_spm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bp_sacc_spm_arbiter
//  Purpose  : Shares a single-port 1RW synchronous scratchpad between the
//             external uncached I/O path and the internal compute sequencer.
//             Internal has default priority; the external side is promoted
//             after starve_limit_p consecutive denied cycles. External
//             responses are held in a 1-entry buffer until yumi.
//  Ports    : clk_i    clock
//             reset_i  asynchronous active-high reset
//             bus      bp_sacc_spm_arbiter_if.slave (ext_*, int_*, mem_*,
//                      perf_conflicts_o)
//  Options  : BP_SACC_SPM_ARB_PERF_EN - enables the 32-bit wrapping conflict
//             counter on perf_conflicts_o; otherwise it is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module bp_sacc_spm_arbiter #(
  parameter int data_width_p   = 64,
  parameter int els_p          = 20,
  parameter int addr_width_p   = 40,
  parameter int starve_limit_p = 4
) (
  input  wire logic             clk_i,
  input  wire logic             reset_i,
  bp_sacc_spm_arbiter_if.slave  bus
);

  localparam int c_idx_w  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int c_widx_w = addr_width_p - 3;
  localparam logic [c_widx_w-1:0] c_els          = c_widx_w'(els_p);
  localparam logic [3:0]          c_starve_limit = 4'(starve_limit_p);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                    r_int_rd_pend;  // int read granted last cycle
  logic                    r_int_oor;      // that read was out of range
  logic                    r_ext_pend;     // ext op granted last cycle
  logic                    r_ext_rd;       // ... and it was a read
  logic                    r_ext_oor;      // ... and it was out of range
  logic                    r_buf_v;        // held external response
  logic [data_width_p-1:0] r_buf_data;
  logic [3:0]              r_starve_cnt;

  // --------------------------------------------------------------------------
  // Address decode: byte address -> word index, range check on full index
  // --------------------------------------------------------------------------
  logic [c_widx_w-1:0] w_ext_widx;
  logic [c_widx_w-1:0] w_int_widx;
  logic                w_ext_oor;
  logic                w_int_oor;
  logic                w_unused_addr_bits;

  assign w_ext_widx = bus.ext_addr_i[addr_width_p-1:3];
  assign w_int_widx = bus.int_addr_i[addr_width_p-1:3];
  assign w_ext_oor  = (w_ext_widx >= c_els);
  assign w_int_oor  = (w_int_widx >= c_els);
  assign w_unused_addr_bits = ^{bus.ext_addr_i[2:0], bus.int_addr_i[2:0]};

  // --------------------------------------------------------------------------
  // Eligibility and grant
  // --------------------------------------------------------------------------
  logic w_ext_busy;
  logic w_ext_elig;
  logic w_int_elig;
  logic w_starved;
  logic w_ext_grant;
  logic w_int_grant;

  // While a response is in flight or held, the external side may not issue;
  // this keeps at most one outstanding external op and makes the buffer
  // a single entry.
  assign w_ext_busy  = r_ext_pend | r_buf_v;
  assign w_ext_elig  = ~reset_i & bus.ext_v_i & ~w_ext_busy;
  assign w_int_elig  = ~reset_i & bus.int_v_i;
  assign w_starved   = (r_starve_cnt == c_starve_limit);
  assign w_ext_grant = w_ext_elig & (w_starved | ~w_int_elig);
  assign w_int_grant = w_int_elig & ~w_ext_grant;

  assign bus.ext_ready_o = w_ext_grant;
  assign bus.int_ready_o = w_int_grant;

  // --------------------------------------------------------------------------
  // SRAM drive: out-of-range requests are accepted but never reach the array
  // --------------------------------------------------------------------------
  logic [c_widx_w-1:0] w_sel_widx;
  logic                w_sel_w;

  assign w_sel_widx     = w_ext_grant ? w_ext_widx : w_int_widx;
  assign w_sel_w        = w_ext_grant ? bus.ext_w_i : bus.int_w_i;
  assign bus.mem_v_o    = (w_ext_grant & ~w_ext_oor) | (w_int_grant & ~w_int_oor);
  assign bus.mem_w_o    = bus.mem_v_o & w_sel_w;
  assign bus.mem_addr_o = w_sel_widx[c_idx_w-1:0];
  assign bus.mem_data_o = w_ext_grant ? bus.ext_data_i : bus.int_data_i;

  // --------------------------------------------------------------------------
  // Responses. The SRAM output is valid the cycle after the grant and is
  // forwarded combinationally; the ext buffer captures it only if the
  // response was not consumed in that same cycle.
  // --------------------------------------------------------------------------
  logic [data_width_p-1:0] w_ext_rsp_data;

  assign w_ext_rsp_data = (r_ext_rd & ~r_ext_oor) ? bus.mem_data_i : '0;

  assign bus.ext_v_o    = w_ext_busy;
  assign bus.ext_data_o = r_ext_pend ? w_ext_rsp_data : r_buf_data;

  assign bus.int_v_o    = r_int_rd_pend;
  assign bus.int_data_o = r_int_oor ? '0 : bus.mem_data_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_int_rd_pend <= 1'b0;
      r_int_oor     <= 1'b0;
      r_ext_pend    <= 1'b0;
      r_ext_rd      <= 1'b0;
      r_ext_oor     <= 1'b0;
    end else begin
      r_int_rd_pend <= w_int_grant & ~bus.int_w_i;
      r_int_oor     <= w_int_grant & w_int_oor;
      r_ext_pend    <= w_ext_grant;
      r_ext_rd      <= w_ext_grant & ~bus.ext_w_i;
      r_ext_oor     <= w_ext_grant & w_ext_oor;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_buf_v    <= 1'b0;
      r_buf_data <= '0;
    end else if (r_ext_pend && !bus.ext_yumi_i) begin
      r_buf_v    <= 1'b1;
      r_buf_data <= w_ext_rsp_data;
    end else if (r_buf_v && bus.ext_yumi_i) begin
      r_buf_v    <= 1'b0;
      r_buf_data <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied-while-eligible cycles
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_starve_cnt <= 4'd0;
    end else if (w_ext_elig && !w_ext_grant) begin
      r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional conflict counter
  // --------------------------------------------------------------------------
`ifdef BP_SACC_SPM_ARB_PERF_EN
  logic [31:0] r_perf_conflicts;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perf_conflicts <= 32'd0;
    end else if (w_ext_elig && w_int_elig) begin
      r_perf_conflicts <= r_perf_conflicts + 32'd1;
    end
  end

  assign bus.perf_conflicts_o = r_perf_conflicts;
`else
  assign bus.perf_conflicts_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_sacc_spm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_sacc_spm_arbiter
//  Purpose  : Self-checking bench for bp_sacc_spm_arbiter. A cycle-by-cycle
//             vector table covers basic ext/int traffic, out-of-range
//             accesses and priority; hand-written sequences cover
//             starvation, reset during an ext read and the conflict counter.
//             A small behavioural 1RW SRAM with 1-cycle read latency sits on
//             the mem_* port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_sacc_spm_arbiter;

  localparam int DW = 64;
  localparam int ELS = 20;
  localparam int AW = 40;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  bp_sacc_spm_arbiter_if #(.data_width_p(DW), .els_p(ELS), .addr_width_p(AW)) bus ();

  bp_sacc_spm_arbiter #(
    .data_width_p(DW), .els_p(ELS), .addr_width_p(AW), .starve_limit_p(LIMIT)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM
  logic [DW-1:0] mem_model [ELS];
  logic [DW-1:0] mem_rdata;
  initial begin
    for (int i = 0; i < ELS; i++) mem_model[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (bus.mem_v_o) begin
      if (bus.mem_w_o) mem_model[bus.mem_addr_o] <= bus.mem_data_o;
      else             mem_rdata <= mem_model[bus.mem_addr_o];
    end
  end
  assign bus.mem_data_i = mem_rdata;

  typedef struct {
    logic [63:0] ev, ew, ea, ed, ey;
    logic [63:0] iv, iw, ia, id;
    logic [63:0] x_er, x_ir, x_mv, x_mw, x_ma, x_md;
    logic [63:0] x_ev, x_ed, x_iv, x_id;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic [63:0] ev, ew, ea, ed, ey, iv, iw, ia, id,
    input logic [63:0] er, ir, mv, mw, ma, md, evo, edo, ivo, ido);
    vec_t v;
    v.ev = ev; v.ew = ew; v.ea = ea; v.ed = ed; v.ey = ey;
    v.iv = iv; v.iw = iw; v.ia = ia; v.id = id;
    v.x_er = er; v.x_ir = ir; v.x_mv = mv; v.x_mw = mw; v.x_ma = ma; v.x_md = md;
    v.x_ev = evo; v.x_ed = edo; v.x_iv = ivo; v.x_id = ido;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ev, input logic ew, input logic [63:0] ea,
                        input logic [63:0] ed, input logic ey,
                        input logic iv, input logic iw, input logic [63:0] ia,
                        input logic [63:0] id);
    bus.ext_v_i    = ev;
    bus.ext_w_i    = ew;
    bus.ext_addr_i = ea[AW-1:0];
    bus.ext_data_i = ed;
    bus.ext_yumi_i = ey;
    bus.int_v_i    = iv;
    bus.int_w_i    = iw;
    bus.int_addr_i = ia[AW-1:0];
    bus.int_data_i = id;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 3 units later, well away from both clock edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input int r, input vec_t v);
    chk($sformatf("row%0d ext_ready", r), 64'(bus.ext_ready_o), v.x_er);
    chk($sformatf("row%0d int_ready", r), 64'(bus.int_ready_o), v.x_ir);
    chk($sformatf("row%0d mem_v", r), 64'(bus.mem_v_o), v.x_mv);
    chk($sformatf("row%0d mem_w", r), 64'(bus.mem_w_o), v.x_mw);
    if (v.x_mv[0]) chk($sformatf("row%0d mem_addr", r), 64'(bus.mem_addr_o), v.x_ma);
    if (v.x_mv[0] && v.x_mw[0]) chk($sformatf("row%0d mem_data", r), bus.mem_data_o, v.x_md);
    chk($sformatf("row%0d ext_v_o", r), 64'(bus.ext_v_o), v.x_ev);
    if (v.x_ev[0]) chk($sformatf("row%0d ext_data_o", r), bus.ext_data_o, v.x_ed);
    chk($sformatf("row%0d int_v_o", r), 64'(bus.int_v_o), v.x_iv);
    if (v.x_iv[0]) chk($sformatf("row%0d int_data_o", r), bus.int_data_o, v.x_id);
  endtask

  logic [31:0] exp_perf;

  initial begin
    //          ev ew ea     ed      ey  iv iw ia     id       er ir mv mw ma md       evo edo      ivo ido
    vt[0]  = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       0, 0,        0, 0);
    vt[1]  = mk(1, 1, 'h10,  'hDEAD, 0,  0, 0, 0,     0,       1, 0, 1, 1, 2, 'hDEAD,  0, 0,        0, 0);
    vt[2]  = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 0,        0, 0);
    vt[3]  = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 0,        0, 0);
    vt[4]  = mk(1, 0, 'h10,  0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 0,        0, 0);
    vt[5]  = mk(1, 0, 'h10,  0,      1,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 0,        0, 0);
    vt[6]  = mk(1, 0, 'h10,  0,      0,  0, 0, 0,     0,       1, 0, 1, 0, 2, 0,       0, 0,        0, 0);
    vt[7]  = mk(1, 0, 'h10,  0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 'hDEAD,   0, 0);
    vt[8]  = mk(1, 0, 'h10,  0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 'hDEAD,   0, 0);
    vt[9]  = mk(0, 0, 0,     0,      1,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 'hDEAD,   0, 0);
    vt[10] = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       0, 0,        0, 0);
    vt[11] = mk(0, 0, 0,     0,      0,  1, 1, 'h18,  'h1234,  0, 1, 1, 1, 3, 'h1234,  0, 0,        0, 0);
    vt[12] = mk(0, 0, 0,     0,      0,  1, 0, 'h18,  0,       0, 1, 1, 0, 3, 0,       0, 0,        0, 0);
    vt[13] = mk(0, 0, 0,     0,      0,  1, 0, 'hA0,  0,       0, 1, 0, 0, 0, 0,       0, 0,        1, 'h1234);
    vt[14] = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       0, 0,        1, 0);
    vt[15] = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       0, 0,        0, 0);
    vt[16] = mk(1, 1, 'h08,  'hAA,   0,  1, 1, 'h20,  'hBB,    0, 1, 1, 1, 4, 'hBB,    0, 0,        0, 0);
    vt[17] = mk(1, 1, 'h08,  'hAA,   0,  0, 0, 0,     0,       1, 0, 1, 1, 1, 'hAA,    0, 0,        0, 0);
    vt[18] = mk(0, 0, 0,     0,      1,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 0,        0, 0);
    vt[19] = mk(1, 1, 'hA8,  'h55,   0,  0, 0, 0,     0,       1, 0, 0, 0, 0, 0,       0, 0,        0, 0);
    vt[20] = mk(0, 0, 0,     0,      1,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 0,        0, 0);
    vt[21] = mk(0, 0, 0,     0,      0,  1, 0, 'h20,  0,       0, 1, 1, 0, 4, 0,       0, 0,        0, 0);
    vt[22] = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       0, 0,        1, 'hBB);
    vt[23] = mk(1, 0, 'h08,  0,      0,  0, 0, 0,     0,       1, 0, 1, 0, 1, 0,       0, 0,        0, 0);
    vt[24] = mk(0, 0, 0,     0,      1,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       1, 'hAA,     0, 0);
    vt[25] = mk(0, 0, 0,     0,      0,  0, 0, 0,     0,       0, 0, 0, 0, 0, 0,       0, 0,        0, 0);

    // ---------------- reset state, with both requesters asserting ----------
    rst = 1'b1;
    set_in(1, 1, 'h10, 'h77, 1, 1, 0, 'h18, 0);
    @(posedge clk);
    #4;
    chk("reset ext_ready", 64'(bus.ext_ready_o), 0);
    chk("reset int_ready", 64'(bus.int_ready_o), 0);
    chk("reset mem_v", 64'(bus.mem_v_o), 0);
    chk("reset mem_w", 64'(bus.mem_w_o), 0);
    chk("reset ext_v_o", 64'(bus.ext_v_o), 0);
    chk("reset int_v_o", 64'(bus.int_v_o), 0);
    chk("reset perf", 64'(bus.perf_conflicts_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- vector table ----------------
    for (int r = 0; r < NV; r++) begin
      tick();
      set_in(vt[r].ev[0], vt[r].ew[0], vt[r].ea, vt[r].ed, vt[r].ey[0],
             vt[r].iv[0], vt[r].iw[0], vt[r].ia, vt[r].id);
      #3;
      check_row(r, vt[r]);
    end

    // ---------------- starvation: int reads continuously ----------------
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= LIMIT + 1; k++) begin
        tick();
        set_in(1, 0, 'h18, 0, 0, 1, 0, 'h18, 0);
        #3;
        chk($sformatf("starve%0d c%0d ext_ready", rep, k), 64'(bus.ext_ready_o), (k == LIMIT + 1) ? 64'd1 : 64'd0);
        chk($sformatf("starve%0d c%0d int_ready", rep, k), 64'(bus.int_ready_o), (k == LIMIT + 1) ? 64'd0 : 64'd1);
        if (k >= 2) begin
          chk($sformatf("starve%0d c%0d int_v_o", rep, k), 64'(bus.int_v_o), 1);
          chk($sformatf("starve%0d c%0d int_data", rep, k), bus.int_data_o, 'h1234);
        end
      end
      tick();
      set_in(0, 0, 0, 0, 1, 1, 0, 'h18, 0);
      #3;
      chk($sformatf("starve%0d rsp ext_v_o", rep), 64'(bus.ext_v_o), 1);
      chk($sformatf("starve%0d rsp ext_data", rep), bus.ext_data_o, 'h1234);
      chk($sformatf("starve%0d rsp int_ready", rep), 64'(bus.int_ready_o), 1);
      chk($sformatf("starve%0d rsp int_v_o", rep), 64'(bus.int_v_o), 0);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("starve tail int_v_o", 64'(bus.int_v_o), 1);
    chk("starve tail ext_v_o", 64'(bus.ext_v_o), 0);

    // ---------------- reset while an ext read is in flight ----------------
    tick();
    set_in(1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rstrd grant", 64'(bus.ext_ready_o), 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #3;
    chk("rstrd during ext_v_o", 64'(bus.ext_v_o), 0);
    tick();
    rst = 1'b0;
    #3;
    chk("rstrd after ext_v_o", 64'(bus.ext_v_o), 0);
    tick();
    set_in(1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rstrd buffer empty", 64'(bus.ext_ready_o), 1);
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #3;
    chk("rstrd reread ext_v_o", 64'(bus.ext_v_o), 1);
    chk("rstrd reread data", bus.ext_data_o, 'hDEAD);

    // ---------------- conflict counter: 3 cycles of dual eligibility -------
    for (int k = 0; k < 3; k++) begin
      tick();
      set_in(1, 1, 'h30, 'h9, 0, 1, 0, 'h18, 0);
      #3;
      chk($sformatf("perf c%0d ext_ready", k), 64'(bus.ext_ready_o), 0);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
`ifdef BP_SACC_SPM_ARB_PERF_EN
    exp_perf = 32'd3;
`else
    exp_perf = 32'd0;
`endif
    chk("perf count", 64'(bus.perf_conflicts_o), 64'(exp_perf));

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
